// File: rtl/event_capture_arb_if.sv
// Capture record port of event_capture_arb: one timestamped edge record
// per valid/ready handshake toward the readout logic.
interface event_capture_arb_if #(
  parameter int N_CH = 4,
  parameter int TS_W = 32
);
  localparam int CH_W = $clog2(N_CH);

  logic            cap_valid;
  logic            cap_ready;
  logic [CH_W-1:0] cap_ch;
  logic            cap_rise;
  logic [TS_W-1:0] cap_ts;

  // Producer side (the capture block)
  modport master (
    output cap_valid,
    output cap_ch,
    output cap_rise,
    output cap_ts,
    input  cap_ready
  );

  // Consumer side (register/readout logic)
  modport slave (
    input  cap_valid,
    input  cap_ch,
    input  cap_rise,
    input  cap_ts,
    output cap_ready
  );
endinterface

// File: rtl/event_capture_arb.sv
// Event timestamp capture: per-channel synchronizer, polarity-selected
// edge detect, one pending slot per channel, and a round-robin drain
// through a registered valid/ready output.
module event_capture_arb #(
  parameter int N_CH        = 4,
  parameter int TS_W        = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [N_CH-1:0]     ev_in,
  input  logic [2*N_CH-1:0]   edge_sel,
  input  logic [TS_W-1:0]     time_in,
  event_capture_arb_if.master cap,
  output logic [N_CH-1:0]     ovf,
  input  logic [N_CH-1:0]     ovf_clr
);

  localparam int               CH_W     = $clog2(N_CH);
  localparam int               ARM_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);
  localparam int unsigned      N_CH_U   = N_CH;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Synchronizer, delay flop and arm counter
  logic [N_CH-1:0]  sync_q [SYNC_STAGES];
  logic [N_CH-1:0]  dly_q;
  logic [ARM_W-1:0] arm_q, arm_d;
  logic             armed;
  logic [N_CH-1:0]  s_lvl, rise, fall, det;

  // Pending slots
  logic [N_CH-1:0]  pend_q, pend_d;
  logic [N_CH-1:0]  prise_q, prise_d;
  logic [TS_W-1:0]  pts_q [N_CH];
  logic [TS_W-1:0]  pts_d [N_CH];
  logic [N_CH-1:0]  ovf_q, ovf_d, ovf_set;

  // Arbiter
  logic [CH_W-1:0]  ptr_q, ptr_d;
  logic             grant_en, grant_vld;
  logic [CH_W-1:0]  grant_idx, cand;
  logic [N_CH-1:0]  grant_oh;

  // Output register
  state_t           state_q, state_d;
  logic [CH_W-1:0]  cap_ch_q, cap_ch_d;
  logic             cap_rise_q, cap_rise_d;
  logic [TS_W-1:0]  cap_ts_q, cap_ts_d;

  assign s_lvl = sync_q[SYNC_STAGES-1];
  assign rise  = s_lvl & ~dly_q;
  assign fall  = ~s_lvl & dly_q;
  assign armed = (arm_q == ARM_DONE);

  for (genvar k = 0; k < N_CH; k++) begin : g_det
    assign det[k] = armed & ((rise[k] & edge_sel[2*k]) | (fall[k] & edge_sel[2*k+1]));
  end

  // Synchronizer chain and delay flop keep loading while unarmed
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      dly_q <= '0;
    end else begin
      sync_q[0] <= ev_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      dly_q <= s_lvl;
    end
  end

  // Arm counter saturates at SYNC_STAGES+1
  always_comb begin
    arm_d = armed ? arm_q : arm_q + ARM_W'(1);
  end

  // Round-robin search from the pointer; only when the output can take a record
  always_comb begin
    grant_en  = (state_q == IDLE) || cap.cap_ready;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned i = 0; i < N_CH_U; i++) begin
      cand = CH_W'((32'(ptr_q) + i) % N_CH_U);
      if (grant_en && !grant_vld && pend_q[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    grant_oh = grant_vld ? (N_CH'(1) << grant_idx) : '0;
  end

  // Slot update: a slot being granted this cycle may be refilled at once
  always_comb begin
    pend_d  = pend_q;
    prise_d = prise_q;
    pts_d   = pts_q;
    ovf_set = '0;
    for (int unsigned k = 0; k < N_CH_U; k++) begin
      if (det[k]) begin
        if (!pend_q[k] || grant_oh[k]) begin
          pend_d[k]  = 1'b1;
          prise_d[k] = rise[k];
          pts_d[k]   = time_in;
        end else begin
          ovf_set[k] = 1'b1;
        end
      end else if (grant_oh[k]) begin
        pend_d[k] = 1'b0;
      end
    end
    ovf_d = (ovf_q & ~ovf_clr) | ovf_set;
  end

  // Output FSM; grant_vld already implies the register may be (re)loaded
  always_comb begin
    state_d    = state_q;
    cap_ch_d   = cap_ch_q;
    cap_rise_d = cap_rise_q;
    cap_ts_d   = cap_ts_q;
    ptr_d      = ptr_q;
    case (state_q)
      IDLE:    if (grant_vld) state_d = HOLD;
      HOLD:    if (cap.cap_ready && !grant_vld) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (grant_vld) begin
      cap_ch_d   = grant_idx;
      cap_rise_d = prise_q[grant_idx];
      cap_ts_d   = pts_q[grant_idx];
      ptr_d      = CH_W'((32'(grant_idx) + 1) % N_CH_U);
    end
  end

  // State registers for arm counter, slots, arbiter and output
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      arm_q      <= '0;
      pend_q     <= '0;
      prise_q    <= '0;
      for (int unsigned k = 0; k < N_CH_U; k++) pts_q[k] <= '0;
      ovf_q      <= '0;
      ptr_q      <= '0;
      state_q    <= IDLE;
      cap_ch_q   <= '0;
      cap_rise_q <= 1'b0;
      cap_ts_q   <= '0;
    end else begin
      arm_q      <= arm_d;
      pend_q     <= pend_d;
      prise_q    <= prise_d;
      pts_q      <= pts_d;
      ovf_q      <= ovf_d;
      ptr_q      <= ptr_d;
      state_q    <= state_d;
      cap_ch_q   <= cap_ch_d;
      cap_rise_q <= cap_rise_d;
      cap_ts_q   <= cap_ts_d;
    end
  end

  assign cap.cap_valid = (state_q == HOLD);
  assign cap.cap_ch    = cap_ch_q;
  assign cap.cap_rise  = cap_rise_q;
  assign cap.cap_ts    = cap_ts_q;
  assign ovf           = ovf_q;

endmodule

// File: tb/tb_event_capture_arb.sv
// Bench for event_capture_arb: directed table, hand-written corner
// sequences and a randomized run, all checked against an event-level
// reference model running alongside the DUT.
module tb_event_capture_arb;

  localparam int N  = 4;
  localparam int TW = 32;
  localparam int S  = 2;

  logic          clk;
  logic          resetn;
  logic [N-1:0]  ev_in;
  logic [2*N-1:0] edge_sel;
  logic [TW-1:0] time_in;
  logic [N-1:0]  ovf;
  logic [N-1:0]  ovf_clr;

  event_capture_arb_if #(.N_CH(N), .TS_W(TW)) cap_if ();

  event_capture_arb #(.N_CH(N), .TS_W(TW), .SYNC_STAGES(S)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .ev_in    (ev_in),
    .edge_sel (edge_sel),
    .time_in  (time_in),
    .cap      (cap_if),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_err    = 0;
  int n_checks = 0;
  int unsigned tval = 0;

  // ---------------- reference model ----------------
  // Edges are tracked as events: a level change seen at sampling edge n
  // becomes a slot write at edge n+S (if armed and enabled then).
  typedef struct {
    int due;
    int ch;
    bit rise;
  } det_t;

  det_t          m_q[$];
  int            m_edge;
  bit            m_last [N];
  bit            m_pend [N];
  bit            m_prise [N];
  logic [TW-1:0] m_pts [N];
  int            m_ptr;
  bit            m_valid;
  int            m_ch;
  bit            m_rise;
  logic [TW-1:0] m_ts;
  logic [N-1:0]  m_ovf;

  task automatic model_reset();
    m_q.delete();
    m_edge  = 0;
    m_ptr   = 0;
    m_valid = 0;
    m_ch    = 0;
    m_rise  = 0;
    m_ts    = '0;
    m_ovf   = '0;
    for (int k = 0; k < N; k++) begin
      m_last[k]  = 0;
      m_pend[k]  = 0;
      m_prise[k] = 0;
      m_pts[k]   = '0;
    end
  endtask

  task automatic model_step();
    bit            det [N];
    bit            drise [N];
    bit            gen;
    int            g;
    int            gch;
    bit            grise;
    logic [TW-1:0] gts;
    logic [N-1:0]  set;
    if (!resetn) begin
      model_reset();
      return;
    end
    m_edge++;
    for (int k = 0; k < N; k++) begin
      det[k]   = 0;
      drise[k] = 0;
    end
    while (m_q.size() > 0 && m_q[0].due == m_edge) begin
      det_t e;
      e = m_q.pop_front();
      if (edge_sel[2*e.ch + (e.rise ? 0 : 1)]) begin
        det[e.ch]   = 1;
        drise[e.ch] = e.rise;
      end
    end
    // the first sample after reset is compared against the reset level
    // of the chain, which the arm delay always suppresses
    for (int k = 0; k < N; k++) begin
      if (m_edge >= 2 && ev_in[k] != m_last[k])
        m_q.push_back('{due: m_edge + S, ch: k, rise: ev_in[k]});
      m_last[k] = ev_in[k];
    end
    gen = !m_valid || cap_if.cap_ready;
    g   = -1;
    if (gen)
      for (int i = 0; i < N; i++) begin
        int c;
        c = (m_ptr + i) % N;
        if (g < 0 && m_pend[c]) g = c;
      end
    gch = 0; grise = 0; gts = '0;
    if (g >= 0) begin
      gch   = g;
      grise = m_prise[g];
      gts   = m_pts[g];
    end
    set = '0;
    for (int k = 0; k < N; k++) begin
      if (det[k]) begin
        if (!m_pend[k] || g == k) begin
          m_pend[k]  = 1;
          m_prise[k] = drise[k];
          m_pts[k]   = time_in;
        end else begin
          set[k] = 1'b1;
        end
      end else if (g == k) begin
        m_pend[k] = 0;
      end
    end
    m_ovf = (m_ovf & ~ovf_clr) | set;
    if (gen) begin
      if (g >= 0) begin
        m_valid = 1;
        m_ch    = gch;
        m_rise  = grise;
        m_ts    = gts;
        m_ptr   = (g + 1) % N;
      end else begin
        m_valid = 0;
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: DUT and model advance at posedge, compare at negedge,
  // then the timebase advances for the next cycle.
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("model_valid", cap_if.cap_valid, m_valid);
    if (m_valid) begin
      chk("model_ch", cap_if.cap_ch, m_ch);
      chk("model_rise", cap_if.cap_rise, m_rise);
      chk("model_ts", cap_if.cap_ts, m_ts);
    end
    chk("model_ovf", ovf, m_ovf);
    tval++;
    time_in = tval;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    steps(2);
    resetn = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [N-1:0] ev;
    logic         rdy;
    logic         vld;
    logic [1:0]   ch;
    logic         rise;
  } vec_t;

  vec_t tbl [23];

  int unsigned  t1, t2, ta;
  int           cnt;
  bit           r_rise [$];
  logic [TW-1:0] r_ts [$];

  initial begin
    resetn           = 1'b0;
    ev_in            = 4'b0001;
    edge_sel         = 8'b0101_0101;
    time_in          = '0;
    ovf_clr          = '0;
    cap_if.cap_ready = 1'b1;
    model_reset();

    // reset values while held in reset
    steps(2);
    chk("rst_valid", cap_if.cap_valid, 1'b0);
    chk("rst_ch", cap_if.cap_ch, 2'd0);
    chk("rst_rise", cap_if.cap_rise, 1'b0);
    chk("rst_ts", cap_if.cap_ts, 32'd0);
    chk("rst_ovf", ovf, 4'd0);

    // level high through reset release: arm delay suppresses it
    resetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("arm_quiet", cap_if.cap_valid, 1'b0);
    end
    ev_in[0] = 1'b0;
    steps(3);
    ev_in[0] = 1'b1;
    t1 = tval;
    steps(3);
    chk("first_early", cap_if.cap_valid, 1'b0);
    step();
    chk("first_valid", cap_if.cap_valid, 1'b1);
    chk("first_ch", cap_if.cap_ch, 2'd0);
    chk("first_rise", cap_if.cap_rise, 1'b1);
    chk("first_ts", cap_if.cap_ts, t1 + S);
    step();
    chk("first_drained", cap_if.cap_valid, 1'b0);

    // round-robin order table: pointer 0, then pointer 2
    tbl[0]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[2]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[3]  = '{4'b1111, 1'b1, 1'b1, 2'd0, 1'b1};
    tbl[4]  = '{4'b1111, 1'b1, 1'b1, 2'd1, 1'b1};
    tbl[5]  = '{4'b1111, 1'b1, 1'b1, 2'd2, 1'b1};
    tbl[6]  = '{4'b1111, 1'b1, 1'b1, 2'd3, 1'b1};
    tbl[7]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[8]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[9]  = '{4'b0010, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[10] = '{4'b0010, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[11] = '{4'b0010, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[12] = '{4'b0010, 1'b1, 1'b1, 2'd1, 1'b1};
    tbl[13] = '{4'b0000, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[14] = '{4'b0000, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[15] = '{4'b1111, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[16] = '{4'b1111, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[17] = '{4'b1111, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[18] = '{4'b1111, 1'b1, 1'b1, 2'd2, 1'b1};
    tbl[19] = '{4'b1111, 1'b1, 1'b1, 2'd3, 1'b1};
    tbl[20] = '{4'b1111, 1'b1, 1'b1, 2'd0, 1'b1};
    tbl[21] = '{4'b1111, 1'b1, 1'b1, 2'd1, 1'b1};
    tbl[22] = '{4'b1111, 1'b1, 1'b0, 2'd0, 1'b0};

    ev_in = '0;
    do_reset();
    steps(5);
    for (int i = 0; i < 23; i++) begin
      ev_in            = tbl[i].ev;
      cap_if.cap_ready = tbl[i].rdy;
      step();
      chk($sformatf("tbl%0d_valid", i), cap_if.cap_valid, tbl[i].vld);
      if (tbl[i].vld) begin
        chk($sformatf("tbl%0d_ch", i), cap_if.cap_ch, tbl[i].ch);
        chk($sformatf("tbl%0d_rise", i), cap_if.cap_rise, tbl[i].rise);
      end
    end

    // back-pressure: record held stable, slot refilled, third edge overflows
    ev_in = '0;
    steps(4);
    cap_if.cap_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_idle", cap_if.cap_valid, 1'b0);
    end
    for (int i = 0; i < 12; i++) begin
      ev_in[1] = (i % 4) < 2;
      if (i == 0) t1 = tval;
      if (i == 4) t2 = tval;
      step();
      if (i >= 3) chk("bp_hold_ts", cap_if.cap_ts, t1 + S);
    end
    steps(3);
    chk("bp_valid", cap_if.cap_valid, 1'b1);
    chk("bp_ch", cap_if.cap_ch, 2'd1);
    chk("bp_ts", cap_if.cap_ts, t1 + S);
    chk("bp_ovf1", ovf[1], 1'b1);
    cap_if.cap_ready = 1'b1;
    cnt = 0;
    r_ts.delete();
    for (int i = 0; i < 8; i++) begin
      if (cap_if.cap_valid && cap_if.cap_ch == 2'd1) begin
        cnt++;
        r_ts.push_back(cap_if.cap_ts);
      end
      step();
    end
    chk("bp_count", cnt, 2);
    if (r_ts.size() == 2) chk("bp_second_ts", r_ts[1], t2 + S);
    ovf_clr = 4'b0010;
    step();
    ovf_clr = '0;
    chk("bp_ovf_cleared", ovf[1], 1'b0);

    // both-edges on ch1: pulse of 5 cycles gives rise then fall, 5 apart
    edge_sel = 8'b0101_1101;
    r_rise.delete();
    r_ts.delete();
    for (int i = 0; i < 16; i++) begin
      ev_in[1] = (i >= 1 && i < 6);
      step();
      if (cap_if.cap_valid) begin
        r_rise.push_back(cap_if.cap_rise);
        r_ts.push_back(cap_if.cap_ts);
      end
    end
    chk("both_count", r_rise.size(), 2);
    if (r_rise.size() == 2) begin
      chk("both_rise0", r_rise[0], 1'b1);
      chk("both_rise1", r_rise[1], 1'b0);
      chk("both_dts", r_ts[1] - r_ts[0], 32'd5);
    end
    edge_sel = 8'b0101_0101;

    // ovf set wins over a same-cycle clear; clear alone works
    cap_if.cap_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      ev_in[2] = (i % 4) < 2;
      step();
    end
    chk("ovf2_set", ovf[2], 1'b1);
    ev_in[2] = 1'b1;
    steps(2);
    ovf_clr = 4'b0100;
    step();
    ovf_clr = '0;
    chk("ovf2_set_wins", ovf[2], 1'b1);
    ev_in[2] = 1'b0;
    step();
    ovf_clr = 4'b0100;
    step();
    ovf_clr = '0;
    chk("ovf2_clear", ovf[2], 1'b0);

    // async reset with a held record, pending slots and an ovf flag
    ev_in[0] = 1'b1;
    ev_in[3] = 1'b1;
    steps(4);
    ev_in[0] = 1'b0;
    steps(2);
    ev_in[0] = 1'b1;
    steps(4);
    chk("pre_rst_valid", cap_if.cap_valid, 1'b1);
    chk("pre_rst_ovf0", ovf[0], 1'b1);
    #2 resetn = 1'b0;
    #1;
    chk("arst_valid", cap_if.cap_valid, 1'b0);
    chk("arst_ch", cap_if.cap_ch, 2'd0);
    chk("arst_rise", cap_if.cap_rise, 1'b0);
    chk("arst_ts", cap_if.cap_ts, 32'd0);
    chk("arst_ovf", ovf, 4'd0);
    ev_in = 4'b1111;
    steps(2);
    resetn           = 1'b1;
    cap_if.cap_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("arst_no_stale", cap_if.cap_valid, 1'b0);
    end

    // randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) edge_sel = 8'($urandom);
      for (int k = 0; k < N; k++)
        if ($urandom_range(5) == 0) ev_in[k] = ~ev_in[k];
      cap_if.cap_ready = ($urandom_range(9) < 7);
      ovf_clr = ($urandom_range(19) == 0) ? 4'($urandom) : '0;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
